// File: rtl/mem_slot_arbiter_if.sv
// Bus bundle between the CPU core, the DMA/video requester, main memory and the slot arbiter.
// The arbiter takes the slave modport; the environment (CPU, DMA, memory) takes master.
interface mem_slot_arbiter_if #(
   parameter int unsigned ADDR_W = 16
);
   logic [ADDR_W-1:0] cpu_address;
   logic              cpu_we;
   logic [7:0]        cpu_out;
   logic              cpu_ce;
   logic [7:0]        cpu_in;
   logic              dma_req;
   logic [ADDR_W-1:0] dma_addr;
   logic              dma_hold;
   logic              dma_ack;
   logic              dma_valid;
   logic [7:0]        dma_data;
   logic              hold_ack;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata;

   modport slave (
      input  cpu_address, cpu_we, cpu_out, dma_req, dma_addr, dma_hold, mem_rdata,
      output cpu_ce, cpu_in, dma_ack, dma_valid, dma_data, hold_ack, mem_addr, mem_we, mem_wdata
   );

   modport master (
      output cpu_address, cpu_we, cpu_out, dma_req, dma_addr, dma_hold, mem_rdata,
      input  cpu_ce, cpu_in, dma_ack, dma_valid, dma_data, hold_ack, mem_addr, mem_we, mem_wdata
   );
endinterface

// File: rtl/mem_slot_arbiter.sv
// Time-slot arbiter for the shared memory port: one CPU slot per CPU step (ph==0),
// remaining slots to DMA, plus a whole-period burst hold that freezes the CPU.
module mem_slot_arbiter #(
   parameter int unsigned CPU_DIV = 4,
   parameter int unsigned ADDR_W  = 16
) (
   input logic               clock,
   input logic               reset_n,
   mem_slot_arbiter_if.slave bus
);

   localparam int unsigned PH_W = (CPU_DIV > 1) ? $clog2(CPU_DIV) : 1;
   localparam logic [PH_W-1:0] PH_LAST    = PH_W'(CPU_DIV - 1);
   localparam logic [PH_W-1:0] PH_CAPTURE = PH_W'(1);

   typedef enum logic [1:0] {
      SLOT_CPU,
      SLOT_DMA_GRANT,
      SLOT_DMA_IDLE
   } slot_e;

   logic [PH_W-1:0]   ph, ph_nxt;
   logic              run, run_nxt;
   logic              hold_act, hold_act_nxt;
   logic              dma_pend_valid, dma_pend_valid_nxt;
   logic              dma_valid_q, dma_valid_nxt;
   logic [7:0]        dma_data_q, dma_data_nxt;
   logic [7:0]        cpu_in_q, cpu_in_nxt;

   slot_e             slot_c;
   logic              cpu_ce_c;
   logic              mem_we_c;
   logic [ADDR_W-1:0] mem_addr_c;

   // Slot ownership: ph0 belongs to the CPU unless a hold owns the whole period
   always_comb begin
      slot_c = SLOT_DMA_IDLE;
      if ((ph == '0) && !hold_act) begin
         slot_c = SLOT_CPU;
      end else if (bus.dma_req && run) begin
         slot_c = SLOT_DMA_GRANT;
      end
   end

   // Memory port and strobes, decoded from registered phase/hold state
   always_comb begin
      mem_addr_c = bus.dma_addr;
      mem_we_c   = 1'b0;
      if (slot_c == SLOT_CPU) begin
         mem_addr_c = bus.cpu_address;
         mem_we_c   = bus.cpu_we & run;
      end
      cpu_ce_c = (ph == PH_LAST) && !hold_act && run;
   end

   // Next-state: phase wrap, hold sampling at the end of a period, read-data capture
   always_comb begin
      ph_nxt             = ph + PH_W'(1);
      run_nxt            = 1'b1;
      hold_act_nxt       = hold_act;
      cpu_in_nxt         = cpu_in_q;
      dma_pend_valid_nxt = (slot_c == SLOT_DMA_GRANT);
      dma_valid_nxt      = dma_pend_valid;
      dma_data_nxt       = dma_data_q;

      if (ph == PH_LAST) begin
         ph_nxt       = '0;
         hold_act_nxt = bus.dma_hold;
      end
      if ((ph == PH_CAPTURE) && !hold_act) begin
         cpu_in_nxt = bus.mem_rdata;
      end
      // Memory has one cycle of read latency, so DMA data lands one cycle after the grant
      if (dma_pend_valid) begin
         dma_data_nxt = bus.mem_rdata;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ph             <= '0;
         run            <= 1'b0;
         hold_act       <= 1'b0;
         dma_pend_valid <= 1'b0;
         dma_valid_q    <= 1'b0;
         dma_data_q     <= 8'h00;
         cpu_in_q       <= 8'h00;
      end else begin
         ph             <= ph_nxt;
         run            <= run_nxt;
         hold_act       <= hold_act_nxt;
         dma_pend_valid <= dma_pend_valid_nxt;
         dma_valid_q    <= dma_valid_nxt;
         dma_data_q     <= dma_data_nxt;
         cpu_in_q       <= cpu_in_nxt;
      end
   end

   assign bus.cpu_ce    = cpu_ce_c;
   assign bus.cpu_in    = cpu_in_q;
   assign bus.dma_ack   = (slot_c == SLOT_DMA_GRANT);
   assign bus.dma_valid = dma_valid_q;
   assign bus.dma_data  = dma_data_q;
   assign bus.hold_ack  = hold_act;
   assign bus.mem_addr  = mem_addr_c;
   assign bus.mem_we    = mem_we_c;
   assign bus.mem_wdata = bus.cpu_out;

endmodule

// File: tb/tb_mem_slot_arbiter.sv
// Randomized bench for mem_slot_arbiter (CPU_DIV=4) against a cycle-indexed slot model.
module tb_mem_slot_arbiter;

   localparam int unsigned DIV = 4;

   logic clock;
   logic reset_n;

   mem_slot_arbiter_if #(.ADDR_W(16)) bus ();

   mem_slot_arbiter #(.CPU_DIV(DIV), .ADDR_W(16)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Physical memory: synchronous read with one cycle of latency, read-before-write
   logic [7:0] mem [0:65535];
   always @(posedge clock) begin
      bus.mem_rdata <= mem[bus.mem_addr];
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
   end

   // Reference model state
   typedef struct {
      int         due;
      logic [7:0] data;
   } pend_t;

   logic [7:0] ref_mem [0:65535];
   pend_t      dq[$];
   int         k;
   logic       m_hold;
   logic [7:0] exp_cpu_in;
   logic [7:0] exp_dma_data;
   logic [7:0] pend_cpu;
   logic       last_ce;
   logic       last_ack;

   int we_pct, req_pct, hold_pct;
   logic       fix_addr;
   logic [15:0] fixed_addr;

   int total;
   int bad;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, k, got, exp);
      end
   endtask

   task automatic model_reset();
      k            = 0;
      m_hold       = 1'b0;
      exp_cpu_in   = 8'h00;
      exp_dma_data = 8'h00;
      pend_cpu     = 8'h00;
      last_ce      = 1'b0;
      last_ack     = 1'b0;
      dq.delete();
   endtask

   // Expected behaviour of cycle k, from phase = k mod DIV and the current period's hold
   task automatic model_check();
      int   phase;
      logic run, cpu_slot, e_ce, e_we, e_ack, e_valid;
      logic [15:0] e_addr;
      phase    = k % DIV;
      run      = (k >= 1);
      cpu_slot = (phase == 0) && !m_hold;
      e_ce     = (phase == DIV - 1) && !m_hold && run;
      e_we     = cpu_slot && bus.cpu_we && run;
      e_ack    = !cpu_slot && bus.dma_req && run;
      e_addr   = cpu_slot ? bus.cpu_address : bus.dma_addr;
      e_valid  = (dq.size() > 0) && (dq[0].due == k);
      if (e_valid) begin
         exp_dma_data = dq[0].data;
         void'(dq.pop_front());
      end

      check_eq("cpu_ce",    32'(bus.cpu_ce),    32'(e_ce));
      check_eq("mem_we",    32'(bus.mem_we),    32'(e_we));
      check_eq("dma_ack",   32'(bus.dma_ack),   32'(e_ack));
      check_eq("dma_valid", 32'(bus.dma_valid), 32'(e_valid));
      check_eq("hold_ack",  32'(bus.hold_ack),  32'(m_hold));
      check_eq("cpu_in",    32'(bus.cpu_in),    32'(exp_cpu_in));
      check_eq("dma_data",  32'(bus.dma_data),  32'(exp_dma_data));
      check_eq("mem_addr",  32'(bus.mem_addr),  32'(e_addr));
      if (e_we) check_eq("mem_wdata", 32'(bus.mem_wdata), 32'(bus.cpu_out));

      if (cpu_slot) begin
         pend_cpu = ref_mem[bus.cpu_address];
         if (e_we) ref_mem[bus.cpu_address] = bus.cpu_out;
      end
      if ((phase == 1) && !m_hold) exp_cpu_in = pend_cpu;
      if (e_ack) dq.push_back('{due: k + 2, data: ref_mem[bus.dma_addr]});
      if (phase == DIV - 1) m_hold = bus.dma_hold;
      last_ce  = e_ce;
      last_ack = e_ack;
   endtask

   // CPU changes its request only after a completed step; requester advances on each grant
   task automatic drive_next();
      if (last_ce) begin
         bus.cpu_we      = ($urandom_range(0, 99) < we_pct);
         bus.cpu_address = fix_addr ? fixed_addr : 16'h8000 + 16'($urandom_range(0, 63));
         bus.cpu_out     = 8'($urandom);
      end
      if (last_ack) bus.dma_addr = bus.dma_addr + 16'd1;
      bus.dma_req = ($urandom_range(0, 99) < req_pct);
      if ($urandom_range(0, 99) < hold_pct) bus.dma_hold = !bus.dma_hold;
   endtask

   task automatic one_cycle();
      @(negedge clock);
      model_check();
      @(posedge clock);
      #1;
      drive_next();
      k++;
   endtask

   task automatic run_seg(input int n, input int we_p, input int req_p, input int hold_p,
                          input logic hold_v, input logic fix, input logic [15:0] fa);
      we_pct       = we_p;
      req_pct      = req_p;
      hold_pct     = hold_p;
      fix_addr     = fix;
      fixed_addr   = fa;
      bus.dma_hold = hold_v;
      for (int i = 0; i < n; i++) one_cycle();
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_ce"},    32'(bus.cpu_ce),    32'd0);
      check_eq({tag, "_we"},    32'(bus.mem_we),    32'd0);
      check_eq({tag, "_ack"},   32'(bus.dma_ack),   32'd0);
      check_eq({tag, "_valid"}, 32'(bus.dma_valid), 32'd0);
      check_eq({tag, "_hold"},  32'(bus.hold_ack),  32'd0);
      check_eq({tag, "_cpuin"}, 32'(bus.cpu_in),    32'd0);
      check_eq({tag, "_ddata"}, 32'(bus.dma_data),  32'd0);
   endtask

   // Asynchronous reset in the middle of a hold burst, in a ph2 cycle after a grant
   task automatic reset_mid();
      while ((k % DIV) != 2) one_cycle();
      bus.cpu_we  = 1'b1;
      bus.dma_req = 1'b1;
      #2;
      reset_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      repeat (3) @(posedge clock);
      @(negedge clock);
      check_reset_outputs("inrst");
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      model_reset();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      for (int a = 0; a < 65536; a++) begin
         logic [7:0] v;
         v          = 8'($urandom);
         mem[a]     = v;
         ref_mem[a] = v;
      end
      mem[16'h1234]     = 8'hA5;
      ref_mem[16'h1234] = 8'hA5;

      reset_n         = 1'b0;
      bus.cpu_address = 16'h1234;
      bus.cpu_we      = 1'b1;
      bus.cpu_out     = 8'h00;
      bus.dma_req     = 1'b1;
      bus.dma_addr    = 16'h8000;
      bus.dma_hold    = 1'b0;
      model_reset();
      repeat (2) @(posedge clock);
      @(negedge clock);
      check_reset_outputs("rst");
      @(posedge clock);
      #1;
      bus.cpu_we  = 1'b0;
      bus.dma_req = 1'b0;
      reset_n     = 1'b1;

      run_seg(12,  0,   0, 0, 1'b0, 1'b1, 16'h1234);
      run_seg(24,  60,  0, 0, 1'b0, 1'b0, 16'h0000);
      run_seg(24,  30, 100, 0, 1'b0, 1'b0, 16'h0000);
      run_seg(300, 40, 70, 8, 1'b0, 1'b0, 16'h0000);
      run_seg(12,  50, 100, 0, 1'b1, 1'b0, 16'h0000);
      reset_mid();
      run_seg(200, 40, 70, 8, 1'b0, 1'b0, 16'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
